// File: rtl/arb_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM state encoding and
// the grant index used by the round-robin picker.
package arb_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE  = 3'd0,
        ARB_IACC  = 3'd1,
        ARB_DACC  = 3'd2,
        ARB_IDONE = 3'd3,
        ARB_DDONE = 3'd4
    } arb_state_e;

    localparam logic GRANT_IBUS = 1'b0;
    localparam logic GRANT_DBUS = 1'b1;

    function automatic logic [1:0] grant_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin picker. A tie goes to the requester that did not
// win the most recent update; last grant resets to index 0.
module rr_arbiter2
    import arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic [1:0] grant_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        grant_o = 2'b00;
        unique case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = grant_onehot(~last_q);
            default: grant_o = 2'b00;
        endcase

        last_d = last_q;
        if (update_i && (grant_o != 2'b00)) begin
            last_d = grant_o[1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= GRANT_IBUS;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one synchronous-read RAM between the CPU instruction and data buses.
// Each access takes three cycles: capture in IDLE, strobe cycle, completion cycle.
module mem_bus_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clock,
    input  logic                      reset,

    input  logic [ADDR_WIDTH-1:0]     ibus_addr,
    input  logic                      ibus_read,
    output logic [DATA_WIDTH-1:0]     ibus_data,
    output logic                      ibus_stall,

    input  logic [ADDR_WIDTH-1:0]     dbus_addr,
    input  logic                      dbus_read,
    input  logic                      dbus_write,
    input  logic [DATA_WIDTH-1:0]     dbus_wdata,
    input  logic [DATA_WIDTH/8-1:0]   dbus_byteenable,
    output logic [DATA_WIDTH-1:0]     dbus_data,
    output logic                      dbus_stall,

    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [DATA_WIDTH/8-1:0]   mem_byteenable,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    arb_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [BE_WIDTH-1:0]   mem_be_q, mem_be_d;
    logic                  store_q, store_d;

    logic                  dbus_req;
    logic                  in_idle;
    logic [1:0]            req;
    logic [1:0]            grant;

    assign dbus_req = dbus_read | dbus_write;
    assign in_idle  = (state_q == ARB_IDLE);
    assign req      = in_idle ? {dbus_req, ibus_read} : 2'b00;

    rr_arbiter2 u_rr (
        .clk_i    (clock),
        .rst_i    (reset),
        .req_i    (req),
        .update_i (in_idle),
        .grant_o  (grant)
    );

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        store_d     = store_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (grant[0]) begin
                    mem_addr_d  = ibus_addr;
                    mem_read_d  = 1'b1;
                    mem_write_d = 1'b0;
                    mem_be_d    = '1;
                    store_d     = 1'b0;
                    state_d     = ARB_IACC;
                end else if (grant[1]) begin
                    // read+write together is a store
                    mem_addr_d  = dbus_addr;
                    mem_read_d  = ~dbus_write;
                    mem_write_d = dbus_write;
                    mem_wdata_d = dbus_wdata;
                    mem_be_d    = dbus_write ? dbus_byteenable : '1;
                    store_d     = dbus_write;
                    state_d     = ARB_DACC;
                end
            end
            ARB_IACC: begin
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                state_d     = ARB_IDONE;
            end
            ARB_DACC: begin
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                state_d     = ARB_DDONE;
            end
            ARB_IDONE, ARB_DDONE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                state_d     = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            mem_addr_q  <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            store_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            store_q     <= store_d;
        end
    end

    assign mem_addr       = mem_addr_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_byteenable = mem_be_q;

    assign ibus_stall = ibus_read && (state_q != ARB_IDONE);
    assign dbus_stall = dbus_req  && (state_q != ARB_DDONE);
    assign ibus_data  = (state_q == ARB_IDONE) ? mem_rdata : '0;
    assign dbus_data  = ((state_q == ARB_DDONE) && !store_q) ? mem_rdata : '0;

endmodule
